// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared FSM state encoding, digit count and anode patterns
//               for the stopwatch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // Active-low digit enables, one per display position.
    localparam logic [3:0] c_an_dig0 = 4'b1110;
    localparam logic [3:0] c_an_dig1 = 4'b1101;
    localparam logic [3:0] c_an_dig2 = 4'b1011;
    localparam logic [3:0] c_an_dig3 = 4'b0111;
    localparam logic [3:0] c_an_off  = 4'b1111;

    // Anode pattern for a digit index; anything unexpected blanks the display.
    function automatic logic [3:0] anode_for(input logic [IDX_W-1:0] idx);
        logic [3:0] v;
        case (idx)
            2'd0:    v = c_an_dig0;
            2'd1:    v = c_an_dig1;
            2'd2:    v = c_an_dig2;
            2'd3:    v = c_an_dig3;
            default: v = c_an_off;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : 2-flop synchronizer, consecutive-sample debouncer and
//               rising-edge press pulse for one raw push button. A button
//               already held when reset drops is ignored until it has been
//               seen released for DEB_CYCLES samples.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int              c_cw   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DEB_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    logic [1:0]      r_sv;
    logic [c_cw-1:0] r_cnt;
    logic            r_level;
    logic            r_level_d;
    logic            r_block;
    logic [c_cw-1:0] r_rel_cnt;
    logic            r_press;

    // Two-flop synchronizer; r_sv marks when r_s2 holds a real sample again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_sv <= 2'b00;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            r_sv <= {r_sv[0], 1'b1};
        end
    end

    // Accept a new level after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_s2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_level <= r_s2;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // After reset, suppress presses until the button has been seen released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_block   <= 1'b1;
            r_rel_cnt <= '0;
        end else if (r_block) begin
            if (r_sv[1] && !r_s2) begin
                if (r_rel_cnt == c_last) begin
                    r_block <= 1'b0;
                end else begin
                    r_rel_cnt <= r_rel_cnt + 1'b1;
                end
            end else begin
                r_rel_cnt <= '0;
            end
        end
    end

    // One-cycle registered pulse on each rising edge of the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d & ~r_block;
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Start/pause/clear controller for a 4-digit BCD stopwatch
//               counter: button conditioning, IDLE/RUN/PAUSE FSM, tick
//               prescaler and 7-segment display multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic [6:0] one,
    input  logic [6:0] ten,
    input  logic [6:0] hundred,
    input  logic [6:0] thd,
    output logic       cnt_reset,
    output logic       cnt_keep,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       running
);

    localparam int              c_pw        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_tick_last = c_pw'(TICK_DIV - 1);
    localparam int              c_sw        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_sw-1:0] c_scan_last = c_sw'(SCAN_DIV - 1);

    logic             w_start;
    logic             w_clear;
    state_t           r_state;
    state_t           w_next;
    logic             r_cnt_reset;
    logic             r_running;
    logic [c_pw-1:0]  r_presc;
    logic [c_sw-1:0]  r_scan;
    logic [IDX_W-1:0] r_idx;
    logic [6:0]       w_seg_sel;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_start),
        .o_press (w_start)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_clear),
        .o_press (w_clear)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: clear beats start when both pulse together.
    always_comb begin
        w_next = r_state;
        if (w_clear) begin
            w_next = ST_IDLE;
        end else if (w_start) begin
            case (r_state)
                ST_IDLE:  w_next = ST_RUN;
                ST_RUN:   w_next = ST_PAUSE;
                ST_PAUSE: w_next = ST_RUN;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Registered state-decoded outputs, aligned with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_reset <= 1'b1;
            r_running   <= 1'b0;
        end else begin
            r_cnt_reset <= (w_next == ST_IDLE);
            r_running   <= (w_next == ST_RUN);
        end
    end

    // Tick prescaler: counts in RUN, holds in PAUSE, zero in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_next == ST_IDLE) begin
            r_presc <= '0;
        end else if (r_state == ST_RUN) begin
            r_presc <= (r_presc == c_tick_last) ? '0 : r_presc + 1'b1;
        end
    end

    // Free-running scan counter; digit index steps at each terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == c_scan_last) begin
            r_scan <= '0;
            r_idx  <= r_idx + 1'b1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    // Segment source for the current digit index.
    always_comb begin
        w_seg_sel = one;
        case (r_idx)
            2'd0:    w_seg_sel = one;
            2'd1:    w_seg_sel = ten;
            2'd2:    w_seg_sel = hundred;
            2'd3:    w_seg_sel = thd;
            default: w_seg_sel = one;
        endcase
    end

    // Segment bus and anodes registered together so they switch in step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= c_an_off;
            r_seg <= 7'b0;
        end else begin
            r_an  <= anode_for(r_idx);
            r_seg <= w_seg_sel;
        end
    end

    assign cnt_reset = r_cnt_reset;
    assign running   = r_running;
    assign cnt_keep  = ~((r_state == ST_RUN) && (r_presc == c_tick_last));
    assign seg       = r_seg;
    assign an        = r_an;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl with TICK_DIV=4,
//               SCAN_DIV=2, DEB_CYCLES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start;
    logic       btn_clear;
    logic [6:0] one, ten, hundred, thd;
    logic       cnt_reset, cnt_keep, running;
    logic [6:0] seg;
    logic [3:0] an;

    stopwatch_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .DEB_CYCLES(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .one       (one),
        .ten       (ten),
        .hundred   (hundred),
        .thd       (thd),
        .cnt_reset (cnt_reset),
        .cnt_keep  (cnt_keep),
        .seg       (seg),
        .an        (an),
        .running   (running)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct { logic [3:0] an; logic [6:0] seg; } scan_exp_t;
    typedef struct { logic running; logic cnt_reset; } fsm_exp_t;
    typedef enum { A_START, A_CLEAR, A_BOTH, A_GLITCH } act_t;
    typedef struct { act_t act; logic exp_run; logic exp_crst; } vec_t;
    typedef struct { logic [6:0] d0, d1, d2, d3; } digits_t;

    scan_exp_t sb_scan[$];
    fsm_exp_t  sb_fsm[$];
    vec_t      vecs[13];
    digits_t   digs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected display for the coming edge, then compare after it.
    task automatic scan_step(input int rel_first);
        scan_exp_t e;
        int        idx;
        idx = ((cyc + 1 - rel_first) / 2) % 4;
        case (idx)
            0:       begin e.an = 4'b1110; e.seg = one;     end
            1:       begin e.an = 4'b1101; e.seg = ten;     end
            2:       begin e.an = 4'b1011; e.seg = hundred; end
            default: begin e.an = 4'b0111; e.seg = thd;     end
        endcase
        sb_scan.push_back(e);
        tick();
        e = sb_scan.pop_front();
        check("scan_an", {28'd0, an}, {28'd0, e.an});
        check("scan_seg", {25'd0, seg}, {25'd0, e.seg});
    endtask

    task automatic press(input logic s, input logic c, input int hold);
        btn_start = s;
        btn_clear = c;
        repeat (hold) tick();
        btn_start = 1'b0;
        btn_clear = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int rel, e0, j, p0, r0, c0, h, lows, runs, first, second;
        fsm_exp_t fe;

        vecs[0]  = '{A_GLITCH, 1'b0, 1'b1};
        vecs[1]  = '{A_START,  1'b1, 1'b0};
        vecs[2]  = '{A_GLITCH, 1'b1, 1'b0};
        vecs[3]  = '{A_START,  1'b0, 1'b0};
        vecs[4]  = '{A_GLITCH, 1'b0, 1'b0};
        vecs[5]  = '{A_START,  1'b1, 1'b0};
        vecs[6]  = '{A_CLEAR,  1'b0, 1'b1};
        vecs[7]  = '{A_CLEAR,  1'b0, 1'b1};
        vecs[8]  = '{A_START,  1'b1, 1'b0};
        vecs[9]  = '{A_START,  1'b0, 1'b0};
        vecs[10] = '{A_CLEAR,  1'b0, 1'b1};
        vecs[11] = '{A_START,  1'b1, 1'b0};
        vecs[12] = '{A_BOTH,   1'b0, 1'b1};

        digs[0] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
        digs[1] = '{7'h7F, 7'h6F, 7'h77, 7'h7C};
        digs[2] = '{7'h00, 7'h7F, 7'h01, 7'h40};

        reset = 1'b1; btn_start = 1'b0; btn_clear = 1'b0;
        one = digs[0].d0; ten = digs[0].d1; hundred = digs[0].d2; thd = digs[0].d3;

        // Reset values.
        tick(); tick();
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h0);
        check("rst_cnt_reset", {31'd0, cnt_reset}, 32'd1);
        check("rst_cnt_keep", {31'd0, cnt_keep}, 32'd1);
        check("rst_running", {31'd0, running}, 32'd0);

        // Display multiplexing, first edge after release included.
        reset = 1'b0;
        rel = cyc + 1;
        for (int r = 0; r < 3; r++) begin
            one = digs[r].d0; ten = digs[r].d1; hundred = digs[r].d2; thd = digs[r].d3;
            repeat (8) scan_step(rel);
        end

        // Clean start press: RUN from 6 edges after first raw sample, tick every 4.
        btn_start = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 16; k++) begin
            tick();
            j = cyc - e0;
            check($sformatf("startA_running_j%0d", j), {31'd0, running}, (j >= 6) ? 32'd1 : 32'd0);
            check($sformatf("startA_keep_j%0d", j), {31'd0, cnt_keep},
                  (j >= 9 && ((j - 9) % 4) == 0) ? 32'd0 : 32'd1);
            if (j == 7) btn_start = 1'b0;
        end
        repeat (6) tick();

        // Pause, then resume with the tick phase preserved.
        btn_start = 1'b1;
        p0 = cyc + 1;
        repeat (6) tick();
        btn_start = 1'b0;
        tick();
        check("pause_running", {31'd0, running}, 32'd0);
        check("pause_cnt_reset", {31'd0, cnt_reset}, 32'd0);
        h = (p0 - e0) % 4;
        lows = 0; runs = 0;
        repeat (12) begin
            tick();
            if (!cnt_keep) lows++;
            if (running || cnt_reset) runs++;
        end
        check("pause_keep_lows", lows, 0);
        check("pause_outputs_hold", runs, 0);
        btn_start = 1'b1;
        r0 = cyc + 1;
        repeat (6) tick();
        btn_start = 1'b0;
        tick();
        check("resume_running", {31'd0, running}, 32'd1);
        first = -1; second = -1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            if (!cnt_keep) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        check("resume_first_tick", first, r0 + 6 + (3 - h));
        check("resume_tick_period", second - first, 4);
        repeat (4) tick();

        // Start and clear together during RUN.
        btn_start = 1'b1; btn_clear = 1'b1;
        c0 = cyc + 1;
        repeat (6) tick();
        check("both_before_running", {31'd0, running}, 32'd1);
        btn_start = 1'b0; btn_clear = 1'b0;
        tick();
        check("both_running", {31'd0, running}, 32'd0);
        check("both_cnt_reset", {31'd0, cnt_reset}, 32'd1);
        check("both_cnt_keep", {31'd0, cnt_keep}, 32'd1);
        check("both_edge", cyc, c0 + 6);
        repeat (10) tick();

        // Table of button actions with expected state outputs.
        for (int i = 0; i < 13; i++) begin
            sb_fsm.push_back('{vecs[i].exp_run, vecs[i].exp_crst});
            case (vecs[i].act)
                A_START:  press(1'b1, 1'b0, 6);
                A_CLEAR:  press(1'b0, 1'b1, 6);
                A_BOTH:   press(1'b1, 1'b1, 6);
                default:  press(1'b1, 1'b0, 2);
            endcase
            fe = sb_fsm.pop_front();
            check($sformatf("vec%0d_running", i), {31'd0, running}, {31'd0, fe.running});
            check($sformatf("vec%0d_cnt_reset", i), {31'd0, cnt_reset}, {31'd0, fe.cnt_reset});
        end

        // Reset mid-RUN with start held through and after reset.
        press(1'b1, 1'b0, 6);
        check("preD_running", {31'd0, running}, 32'd1);
        btn_start = 1'b1;
        reset = 1'b1;
        tick();
        check("midrst_running", {31'd0, running}, 32'd0);
        check("midrst_cnt_reset", {31'd0, cnt_reset}, 32'd1);
        check("midrst_an", {28'd0, an}, 32'hF);
        check("midrst_seg", {25'd0, seg}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("rel_an", {28'd0, an}, 32'hE);
        check("rel_seg", {25'd0, seg}, {25'd0, one});
        runs = 0;
        repeat (12) begin
            tick();
            if (running) runs++;
        end
        check("held_no_press", runs, 0);
        btn_start = 1'b0;
        repeat (10) tick();
        check("released_idle", {31'd0, running}, 32'd0);
        press(1'b1, 1'b0, 6);
        check("repress_running", {31'd0, running}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
